// File: rtl/sm83_pkg.sv
// Shared types for the SM83 instruction sequencer: decoded control ops, sequencer states,
// the illegal-opcode table and the sign-extension helper.
package sm83_pkg;

    typedef logic [7:0] instr_t;

    typedef enum logic [3:0] {
        CTL_NOP,
        ALU_OP,
        CTL_LD_R8_R8,
        CTL_INC16,
        CTL_DEC16,
        CTL_ALU_HL_R16,
        CTL_LD_R8_D8,
        CTL_LD_R16_D16,
        CTL_JR,
        CTL_JR_COND,
        CTL_LDPTR_D16_SP,
        CTL_LDPTR_R16_A,
        CTL_LDPTR_A_R16,
        CTL_HALT,
        CTL_STOP
    } ctl_op_t;

    typedef enum logic [3:0] {
        S_RST,
        S_FETCH,
        S_DEC,
        S_CB_FETCH,
        S_IMM_LO,
        S_IMM_HI,
        S_MEM_RD,
        S_WR_LO,
        S_WR_HI,
        S_EXEC,
        S_JR,
        S_HALT,
        S_STOP,
        S_LOCK
    } seq_state_t;

    localparam int N_ILLEGAL = 11;
    localparam logic [7:0] ILLEGAL_OPS [N_ILLEGAL] = '{
        8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB, 8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD
    };

    function automatic logic [15:0] sext8_16(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic is_illegal_op(input instr_t op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_ILLEGAL; i++) begin
            if (ILLEGAL_OPS[i] == op) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/sm83_seq_if.sv
// Single-port memory bus between the sequencer (master) and memory (slave).
interface sm83_seq_if;
    // mem_req is held with mem_we/mem_addr/mem_wdata stable until the cycle in which
    // mem_ack is high; that cycle completes the transfer and mem_rdata is valid in it.
    // mem_ack has no meaning while mem_req is low.
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/sm83_bus_port.sv
// Registered request side of the memory port; a new request is accepted only when the
// port is idle or the current transfer is being acknowledged.
module sm83_bus_port (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_d,
    input  logic        we_d,
    input  logic [15:0] addr_d,
    input  logic [7:0]  wdata,
    output logic        done,
    sm83_seq_if.master  mem
);
    logic        req_q;
    logic        we_q;
    logic [15:0] addr_q;

    assign done          = req_q & mem.mem_ack;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= 16'h0000;
        end else if (!req_q || mem.mem_ack) begin
            req_q  <= req_d;
            we_q   <= we_d;
            addr_q <= addr_d;
        end
    end
endmodule

// File: rtl/sm83_seq.sv
// SM83 instruction sequencer: PC/IR/imm ownership, fetch and operand sequencing.
// Define SM83_SEQ_ILLEGAL_TRAP_EN to lock up on illegal opcodes instead of treating them as NOP.
module sm83_seq
    import sm83_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    sm83_seq_if.master  mem,
    output instr_t      ir,
    output logic        ir_is_cb,
    input  ctl_op_t     dec_ctl_op,
    input  logic        dec_is_cb,
    output logic [15:0] imm,
    output logic [15:0] pc,
    output logic        exec_stb,
    output logic        wr_hi,
    input  logic [15:0] dp_addr,
    input  logic [7:0]  dp_wdata,
    input  logic        jr_taken,
    input  logic        wake,
    output logic        halted,
    output logic        stopped,
    output logic        locked,
    output seq_state_t  seq_state
);
    seq_state_t  state, state_d;
    ctl_op_t     op_q, op_d;
    instr_t      ir_d;
    logic        cb_d, done, illegal;
    logic [15:0] pc_d, imm_d;
    logic        req_d, we_d;
    logic [15:0] addr_d;

    assign illegal   = !ir_is_cb && is_illegal_op(ir);
    assign seq_state = state;
    assign exec_stb  = (state == S_EXEC);
    assign wr_hi     = (state == S_WR_HI);
    assign halted    = (state == S_HALT);
    assign stopped   = (state == S_STOP);
`ifdef SM83_SEQ_ILLEGAL_TRAP_EN
    assign locked    = (state == S_LOCK);
`else
    assign locked    = 1'b0;
`endif

    always_comb begin
        state_d = state;
        op_d    = op_q;
        ir_d    = ir;
        cb_d    = ir_is_cb;
        pc_d    = pc;
        imm_d   = imm;
        case (state)
            S_RST: state_d = S_FETCH;
            S_FETCH, S_CB_FETCH: if (done) begin
                ir_d    = mem.mem_rdata;
                cb_d    = (state == S_CB_FETCH);
                pc_d    = pc + 16'd1;
                state_d = S_DEC;
            end
            S_DEC: begin
                op_d = dec_ctl_op;
                if (ir_is_cb) begin
                    op_d    = ALU_OP;
                    state_d = S_EXEC;
                end else if (dec_is_cb) begin
                    state_d = S_CB_FETCH;
                end else if (illegal) begin
                    op_d = CTL_NOP;
`ifdef SM83_SEQ_ILLEGAL_TRAP_EN
                    state_d = S_LOCK;
`else
                    state_d = S_EXEC;
`endif
                end else begin
                    case (dec_ctl_op)
                        CTL_LD_R8_D8, CTL_LD_R16_D16, CTL_JR, CTL_JR_COND,
                        CTL_LDPTR_D16_SP: state_d = S_IMM_LO;
                        CTL_LDPTR_R16_A:  state_d = S_WR_LO;
                        CTL_LDPTR_A_R16:  state_d = S_MEM_RD;
                        CTL_HALT:         state_d = S_HALT;
                        CTL_STOP:         state_d = S_STOP;
                        default:          state_d = S_EXEC;
                    endcase
                end
            end
            S_IMM_LO: if (done) begin
                imm_d[7:0] = mem.mem_rdata;
                pc_d       = pc + 16'd1;
                case (op_q)
                    CTL_LD_R8_D8: state_d = S_EXEC;
                    CTL_JR:       state_d = S_JR;
                    CTL_JR_COND:  state_d = jr_taken ? S_JR : S_FETCH;
                    default:      state_d = S_IMM_HI;
                endcase
            end
            S_IMM_HI: if (done) begin
                imm_d[15:8] = mem.mem_rdata;
                pc_d        = pc + 16'd1;
                state_d     = (op_q == CTL_LDPTR_D16_SP) ? S_WR_LO : S_EXEC;
            end
            S_MEM_RD: if (done) begin
                imm_d[7:0] = mem.mem_rdata;
                state_d    = S_EXEC;
            end
            S_WR_LO: if (done) state_d = (op_q == CTL_LDPTR_D16_SP) ? S_WR_HI : S_EXEC;
            S_WR_HI: if (done) state_d = S_FETCH;
            S_EXEC:  state_d = S_FETCH;
            S_JR: begin
                pc_d    = pc + sext8_16(imm[7:0]);
                state_d = S_FETCH;
            end
            S_HALT, S_STOP: if (wake) state_d = S_FETCH;
            S_LOCK:  state_d = S_LOCK;
            default: state_d = S_RST;
        endcase
    end

    // Request for the state being entered, built from next-cycle PC/imm so it is registered on entry.
    always_comb begin
        req_d  = 1'b0;
        we_d   = 1'b0;
        addr_d = pc_d;
        case (state_d)
            S_FETCH, S_CB_FETCH, S_IMM_LO, S_IMM_HI: req_d = 1'b1;
            S_MEM_RD: begin
                req_d  = 1'b1;
                addr_d = dp_addr;
            end
            S_WR_LO: begin
                req_d  = 1'b1;
                we_d   = 1'b1;
                addr_d = (op_d == CTL_LDPTR_D16_SP) ? imm_d : dp_addr;
            end
            S_WR_HI: begin
                req_d  = 1'b1;
                we_d   = 1'b1;
                addr_d = imm_d + 16'd1;
            end
            default: ;
        endcase
    end

    sm83_bus_port u_bus (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_d  (req_d),
        .we_d   (we_d),
        .addr_d (addr_d),
        .wdata  (dp_wdata),
        .done   (done),
        .mem    (mem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RST;
            op_q     <= CTL_NOP;
            ir       <= 8'h00;
            ir_is_cb <= 1'b0;
            pc       <= RESET_PC;
            imm      <= 16'h0000;
        end else begin
            state    <= state_d;
            op_q     <= op_d;
            ir       <= ir_d;
            ir_is_cb <= cb_d;
            pc       <= pc_d;
            imm      <= imm_d;
        end
    end
endmodule

// File: tb/tb_sm83_seq.sv
// Scoreboard bench for sm83_seq: directed programs, memory responder with variable latency,
// and a monitor comparing reads, writes and execute strobes against expected queues.
`timescale 1ns/1ps
module tb_sm83_seq;
    import sm83_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sm83_seq_if bus ();
    instr_t      ir;
    logic        ir_is_cb, dec_is_cb, exec_stb, wr_hi, jr_taken, wake;
    logic        halted, stopped, locked;
    ctl_op_t     dec_ctl_op;
    logic [15:0] imm, pc, dp_addr, sp;
    logic [7:0]  dp_wdata;
    seq_state_t  seq_state;

    sm83_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (bus),
        .ir         (ir),
        .ir_is_cb   (ir_is_cb),
        .dec_ctl_op (dec_ctl_op),
        .dec_is_cb  (dec_is_cb),
        .imm        (imm),
        .pc         (pc),
        .exec_stb   (exec_stb),
        .wr_hi      (wr_hi),
        .dp_addr    (dp_addr),
        .dp_wdata   (dp_wdata),
        .jr_taken   (jr_taken),
        .wake       (wake),
        .halted     (halted),
        .stopped    (stopped),
        .locked     (locked),
        .seq_state  (seq_state)
    );

    // decode and datapath stand-ins
    always_comb begin
        dec_is_cb  = !ir_is_cb && (ir == 8'hCB);
        dec_ctl_op = CTL_NOP;
        if (ir_is_cb) dec_ctl_op = ALU_OP;
        else begin
            case (ir)
                8'h01: dec_ctl_op = CTL_LD_R16_D16;
                8'h02: dec_ctl_op = CTL_LDPTR_R16_A;
                8'h08: dec_ctl_op = CTL_LDPTR_D16_SP;
                8'h0A: dec_ctl_op = CTL_LDPTR_A_R16;
                8'h10: dec_ctl_op = CTL_STOP;
                8'h18: dec_ctl_op = CTL_JR;
                8'h20: dec_ctl_op = CTL_JR_COND;
                8'h3E: dec_ctl_op = CTL_LD_R8_D8;
                8'h76: dec_ctl_op = CTL_HALT;
                default: dec_ctl_op = CTL_NOP;
            endcase
        end
    end
    assign dp_wdata = wr_hi ? sp[15:8] : sp[7:0];

    // scoreboard state
    logic [15:0] rd_exp_q[$];
    logic [24:0] wr_exp_q[$];
    logic [40:0] ex_exp_q[$];
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_ex_cyc = 0;
    int lat = 1;
    int wcnt = 0;
    int jr_takes = 0;
    int jr_cnt = 0;
    logic [7:0] ram [0:65535];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s_unexpected: got %h, expected none", name, act);
    endtask

    // memory responder: ack in the lat-th request cycle
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        jr_taken      = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (!rst_n || !bus.mem_req) wcnt = 0;
            else begin
                wcnt++;
                if (wcnt >= lat) begin
                    bus.mem_ack = 1'b1;
                    wcnt = 0;
                    if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
                    else begin
                        bus.mem_rdata = ram[bus.mem_addr];
                        if (bus.mem_addr == 16'h0011) begin
                            jr_taken = (jr_cnt < jr_takes);
                            jr_cnt++;
                        end
                    end
                end
            end
        end
    end

    // monitor
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            cyc++;
            if (bus.mem_req && bus.mem_ack) begin
                if (bus.mem_we) begin
                    if (wr_exp_q.size() == 0) unexpected("wr", {bus.mem_addr, bus.mem_wdata, wr_hi});
                    else chk("wr", {bus.mem_addr, bus.mem_wdata, wr_hi}, wr_exp_q.pop_front());
                end else begin
                    if (rd_exp_q.size() == 0) unexpected("rd", bus.mem_addr);
                    else chk("rd_addr", bus.mem_addr, rd_exp_q.pop_front());
                end
            end
            if (exec_stb) begin
                last_ex_cyc = cyc;
                if (ex_exp_q.size() == 0) unexpected("exec", {ir_is_cb, ir, imm, pc});
                else chk("exec", {ir_is_cb, ir, imm, pc}, ex_exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic enter_reset();
        rst_n = 1'b0;
        wake = 1'b0;
        jr_takes = 0;
        jr_cnt = 0;
        lat = 1;
        sp = 16'hABCD;
        dp_addr = 16'h0000;
        repeat (2) @(negedge clk);
        chk("reset_out", {pc, ir, imm, ir_is_cb, bus.mem_req, exec_stb, wr_hi, halted, stopped, locked},
            {16'h0000, 8'h00, 16'h0000, 7'b0});
        rd_exp_q.delete();
        wr_exp_q.delete();
        ex_exp_q.delete();
        for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
    endtask

    task automatic leave_reset();
        cyc = 0;
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (!(halted || stopped || locked) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idle", halted || stopped || locked, 1'b1);
    endtask

    task automatic end_check(input string name);
        chk({name, "_rd_left"}, rd_exp_q.size(), 0);
        chk({name, "_wr_left"}, wr_exp_q.size(), 0);
        chk({name, "_ex_left"}, ex_exp_q.size(), 0);
    endtask

    task automatic count_req(input int cycles, output int n_req);
        n_req = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.mem_req) n_req++;
        end
    endtask

    initial begin
        int n_req;
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_req;
        // NOP then HALT, zero-wait
        enter_reset();
        ram[0] = 8'h00; ram[1] = 8'h76;
        rd_exp_q.push_back(16'h0000);
        ex_exp_q.push_back({1'b0, 8'h00, 16'h0000, 16'h0001});
        rd_exp_q.push_back(16'h0001);
        leave_reset();
        @(negedge clk);
        chk("first_req", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0000});
        repeat (2) @(negedge clk);
        chk("nop_exec_pc", {exec_stb, pc}, {1'b1, 16'h0001});
        wait_idle(50);
        chk("nop_ex_cyc", last_ex_cyc, 3);
        chk("nop_halted", halted, 1'b1);
        end_check("nop");

        // LD A,d8 with one wait state per byte
        enter_reset();
        ram[0] = 8'h3E; ram[1] = 8'h5A; ram[2] = 8'h76;
        lat = 2;
        rd_exp_q.push_back(16'h0000);
        rd_exp_q.push_back(16'h0001);
        ex_exp_q.push_back({1'b0, 8'h3E, 16'h005A, 16'h0002});
        rd_exp_q.push_back(16'h0002);
        leave_reset();
        wait_idle(100);
        chk("ldd8_ex_cyc", last_ex_cyc, 6);
        end_check("ldd8");

        // JR +0E to 0010, then JR NZ,-2 taken once, then not taken
        for (int t = 1; t >= 0; t--) begin
            enter_reset();
            ram[16'h0000] = 8'h18; ram[16'h0001] = 8'h0E;
            ram[16'h0010] = 8'h20; ram[16'h0011] = 8'hFE; ram[16'h0012] = 8'h76;
            jr_takes = t;
            rd_exp_q.push_back(16'h0000);
            rd_exp_q.push_back(16'h0001);
            rd_exp_q.push_back(16'h0010);
            rd_exp_q.push_back(16'h0011);
            if (t == 1) begin
                rd_exp_q.push_back(16'h0010);
                rd_exp_q.push_back(16'h0011);
            end
            rd_exp_q.push_back(16'h0012);
            leave_reset();
            wait_idle(100);
            chk("jr_pc", pc, 16'h0013);
            end_check("jr");
        end

        // LD (a16),SP
        enter_reset();
        ram[0] = 8'h08; ram[1] = 8'hFE; ram[2] = 8'hFF; ram[3] = 8'h76;
        rd_exp_q.push_back(16'h0000);
        rd_exp_q.push_back(16'h0001);
        rd_exp_q.push_back(16'h0002);
        wr_exp_q.push_back({16'hFFFE, 8'hCD, 1'b0});
        wr_exp_q.push_back({16'hFFFF, 8'hAB, 1'b1});
        rd_exp_q.push_back(16'h0003);
        leave_reset();
        wait_idle(100);
        chk("ldsp_imm_pc", {imm, pc}, {16'hFFFE, 16'h0004});
        end_check("ldsp");

        // CB 37, HALT, wake, NOP, STOP
        enter_reset();
        ram[0] = 8'hCB; ram[1] = 8'h37; ram[2] = 8'h76; ram[3] = 8'h00; ram[4] = 8'h10;
        rd_exp_q.push_back(16'h0000);
        rd_exp_q.push_back(16'h0001);
        ex_exp_q.push_back({1'b1, 8'h37, 16'h0000, 16'h0002});
        rd_exp_q.push_back(16'h0002);
        leave_reset();
        wait_idle(100);
        chk("cb_halted", {halted, stopped}, 2'b10);
        count_req(20, n_req);
        chk("halt_quiet", n_req, 0);
        rd_exp_q.push_back(16'h0003);
        ex_exp_q.push_back({1'b0, 8'h00, 16'h0000, 16'h0004});
        rd_exp_q.push_back(16'h0004);
        wake = 1'b1;
        @(negedge clk);
        wake = 1'b0;
        chk("wake_left_halt", halted, 1'b0);
        wait_idle(100);
        chk("stop_status", {halted, stopped}, 2'b01);
        end_check("cbhalt");

        // LD r16,d16 / LD A,(r16) / LD (r16),A
        enter_reset();
        ram[0] = 8'h01; ram[1] = 8'h34; ram[2] = 8'h12; ram[3] = 8'h0A; ram[4] = 8'h02; ram[5] = 8'h76;
        ram[16'h1234] = 8'h77;
        dp_addr = 16'h1234;
        rd_exp_q.push_back(16'h0000);
        rd_exp_q.push_back(16'h0001);
        rd_exp_q.push_back(16'h0002);
        ex_exp_q.push_back({1'b0, 8'h01, 16'h1234, 16'h0003});
        rd_exp_q.push_back(16'h0003);
        rd_exp_q.push_back(16'h1234);
        ex_exp_q.push_back({1'b0, 8'h0A, 16'h1277, 16'h0004});
        rd_exp_q.push_back(16'h0004);
        wr_exp_q.push_back({16'h1234, 8'hCD, 1'b0});
        ex_exp_q.push_back({1'b0, 8'h02, 16'h1277, 16'h0005});
        rd_exp_q.push_back(16'h0005);
        leave_reset();
        wait_idle(100);
        chk("ptr_pc", pc, 16'h0006);
        end_check("ptr");

        // illegal opcode D3
        enter_reset();
        ram[0] = 8'hD3; ram[1] = 8'h76;
        rd_exp_q.push_back(16'h0000);
`ifdef SM83_SEQ_ILLEGAL_TRAP_EN
        leave_reset();
        wait_idle(50);
        chk("ill_locked", {locked, halted}, 2'b10);
        wake = 1'b1;
        count_req(100, n_req);
        wake = 1'b0;
        chk("ill_quiet", n_req, 0);
        chk("ill_still_locked", locked, 1'b1);
`else
        ex_exp_q.push_back({1'b0, 8'hD3, 16'h0000, 16'h0001});
        rd_exp_q.push_back(16'h0001);
        leave_reset();
        wait_idle(50);
        chk("ill_nop", {locked, halted, pc}, {2'b01, 16'h0002});
`endif
        end_check("ill");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
